// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, PC word width
// and the default reset address.
package pc_seq_pkg;

    localparam int PC_WORD_W = 30;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INCR  = 2'd1,
        BRADD = 2'd2
    } state_t;

    // Branch offsets are signed word counts, widened to the PC word width.
    function automatic logic [PC_WORD_W-1:0] sext_imm16(input logic [15:0] imm);
        return {{(PC_WORD_W - 16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Step request / PC result bundle between an instruction-fetch requester
// (master) and the PC sequencer (slave).
interface pc_seq_if;

    logic        step_valid;
    logic        step_ready;
    logic        branch;
    logic [15:0] imm16;
    logic        jump;
    logic [25:0] jtarget;
    logic [31:0] pc;
    logic        pc_valid;

    modport master (
        output step_valid, branch, imm16, jump, jtarget,
        input  step_ready, pc, pc_valid
    );

    modport slave (
        input  step_valid, branch, imm16, jump, jtarget,
        output step_ready, pc, pc_valid
    );

endinterface

// File: rtl/pc_adder30.sv
// The single word-address adder of the PC sequencer; any carry out of bit 29
// is dropped, so PC arithmetic wraps modulo 2^30 words.
module pc_adder30
    import pc_seq_pkg::*;
(
    input  logic [PC_WORD_W-1:0] a,
    input  logic [PC_WORD_W-1:0] b,
    output logic [PC_WORD_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: accepts one step at a time and time-shares one 30-bit adder
// between the increment and the branch-target add. Define PC_SEQ_JUMP_EN to
// honour the absolute-jump inputs; otherwise they are ignored.
module pc_seq_ctrl
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic       clk,
    input  logic       rst,
    pc_seq_if.slave    bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic [PC_WORD_W-1:0]   pc_w;
    logic [PC_WORD_W-1:0]   npc;
    logic [PC_WORD_W-1:0]   add_a;
    logic [PC_WORD_W-1:0]   add_b;
    logic [PC_WORD_W-1:0]   add_sum;
    logic                   br_q;
    logic                   jmp_q;
    logic [15:0]            imm_q;
    logic [25:0]            jt_q;
    logic                   pc_valid_q;
    logic                   accept;
    logic                   take_jump;

    assign accept = (state == IDLE) && bus.step_valid;

`ifdef PC_SEQ_JUMP_EN
    assign take_jump = jmp_q;
`else
    logic unused_jump;
    assign unused_jump = jmp_q ^ (^jt_q);
    assign take_jump   = 1'b0;
`endif

    // BRADD reuses the adder on the incremented PC; every other state increments.
    always_comb begin
        add_a = pc_w;
        add_b = {{(PC_WORD_W - 1){1'b0}}, 1'b1};
        if (state == BRADD) begin
            add_a = npc;
            add_b = sext_imm16(imm_q);
        end
    end

    pc_adder30 u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = INCR;
            INCR:    state_nxt = (!take_jump && br_q) ? BRADD : IDLE;
            BRADD:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Controls are captured only at acceptance; the PC moves only on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_w       <= RESET_PC[31:2];
            npc        <= '0;
            br_q       <= 1'b0;
            jmp_q      <= 1'b0;
            imm_q      <= '0;
            jt_q       <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            pc_valid_q <= 1'b0;
            if (accept) begin
                br_q  <= bus.branch;
                jmp_q <= bus.jump;
                imm_q <= bus.imm16;
                jt_q  <= bus.jtarget;
            end
            case (state)
                INCR: begin
                    npc <= add_sum;
                    if (take_jump) begin
                        pc_w       <= {add_sum[29:26], jt_q};
                        pc_valid_q <= 1'b1;
                    end else if (!br_q) begin
                        pc_w       <= add_sum;
                        pc_valid_q <= 1'b1;
                    end
                end
                BRADD: begin
                    pc_w       <= add_sum;
                    pc_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.step_ready = (state == IDLE);
    assign bus.pc         = {pc_w, 2'b00};
    assign bus.pc_valid   = pc_valid_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: expected PCs are queued as steps are
// driven and checked whenever the sequencer pulses pc_valid.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RST_PC_A = 32'h0040_0000;
    localparam logic [31:0] RST_PC_B = 32'hFFFF_FFFC;

    logic clk;
    logic rst;

    pc_seq_if a_if ();
    pc_seq_if b_if ();

    pc_seq_ctrl #(.RESET_PC(RST_PC_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    pc_seq_ctrl #(.RESET_PC(RST_PC_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int          compare_count  = 0;
    int          mismatch_count = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Every pc_valid pulse of dut_a must match the oldest outstanding step.
    always @(negedge clk) begin
        if (!rst && a_if.pc_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pc_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("pc_commit", a_if.pc, exp_q.pop_front());
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC_A;
    endtask

    task automatic applyStimulus(input logic br, input logic [15:0] imm,
                                 input logic jmp, input logic [25:0] jt);
        logic [31:0] seq_pc;
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        int          exp_lat;
        int          n;
        int          waited;
        bit          seen;

        seq_pc  = model_pc + 32'd4;
        exp_pc  = seq_pc;
        exp_lat = 1;
`ifdef PC_SEQ_JUMP_EN
        if (jmp) begin
            exp_pc = {seq_pc[31:28], jt, 2'b00};
        end else
`endif
        if (br) begin
            exp_pc  = seq_pc + {{14{imm[15]}}, imm, 2'b00};
            exp_lat = 2;
        end

        @(negedge clk);
        waited = 0;
        while (!a_if.step_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!a_if.step_ready) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end

        a_if.step_valid = 1'b1;
        a_if.branch     = br;
        a_if.imm16      = imm;
        a_if.jump       = jmp;
        a_if.jtarget    = jt;
        exp_q.push_back(exp_pc);
        prev_pc = a_if.pc;

        @(negedge clk);
        a_if.step_valid = 1'b0;
        a_if.branch     = 1'b0;
        a_if.jump       = 1'b0;
        n    = 0;
        seen = 0;
        while (n < 8) begin
            if (a_if.pc_valid) begin
                seen = 1;
                break;
            end
            checkOutput("ready_low_busy", {31'd0, a_if.step_ready}, 32'd0);
            checkOutput("pc_hold_busy", a_if.pc, prev_pc);
            @(negedge clk);
            n++;
        end
        checkOutput("commit_latency", seen ? n : 32'hFFFF, exp_lat);
        model_pc = exp_pc;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        a_if.step_valid = 1'b0;
        a_if.branch     = 1'b0;
        a_if.imm16      = '0;
        a_if.jump       = 1'b0;
        a_if.jtarget    = '0;
        b_if.step_valid = 1'b0;
        b_if.branch     = 1'b0;
        b_if.imm16      = '0;
        b_if.jump       = 1'b0;
        b_if.jtarget    = '0;

        doReset();
        checkOutput("reset_pc", a_if.pc, RST_PC_A);
        checkOutput("reset_ready", {31'd0, a_if.step_ready}, 32'd1);
        checkOutput("reset_pc_valid", {31'd0, a_if.pc_valid}, 32'd0);
        checkOutput("reset_pc_b", b_if.pc, RST_PC_B);

        // Wrap from the top of the address space on the second instance.
        b_if.step_valid = 1'b1;
        @(negedge clk);
        b_if.step_valid = 1'b0;
        begin
            int waited;
            waited = 0;
            while (!b_if.pc_valid && waited < 10) begin
                @(negedge clk);
                waited++;
            end
        end
        checkOutput("wrap_pc_valid_b", {31'd0, b_if.pc_valid}, 32'd1);
        checkOutput("wrap_pc_b", b_if.pc, 32'h0000_0000);

        applyStimulus(1'b0, 16'h0000, 1'b0, 26'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 26'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 26'h0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 26'h0);
        checkOutput("pc_before_branch", a_if.pc, 32'h0040_0010);
        applyStimulus(1'b1, 16'hFFFC, 1'b0, 26'h0);
        checkOutput("pc_after_back_branch", a_if.pc, 32'h0040_0004);

        doReset();
        checkOutput("reset_again_pc", a_if.pc, RST_PC_A);
        applyStimulus(1'b1, 16'h0010, 1'b1, 26'h000_0100);
`ifdef PC_SEQ_JUMP_EN
        checkOutput("jump_wins_pc", a_if.pc, 32'h0000_0400);
`else
        checkOutput("jump_ignored_pc", a_if.pc, 32'h0040_0044);
`endif

        applyStimulus(1'b1, 16'h8000, 1'b0, 26'h0);
        applyStimulus(1'b1, 16'h7FFF, 1'b0, 26'h0);
        applyStimulus(1'b0, 16'h1234, 1'b1, 26'h3FF_FFFF);
        applyStimulus(1'b1, 16'h0003, 1'b0, 26'h0);

        // Abort a branch in BRADD while step_valid stays asserted throughout.
        @(negedge clk);
        a_if.step_valid = 1'b1;
        a_if.branch     = 1'b1;
        a_if.imm16      = 16'h0005;
        a_if.jump       = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready_incr", {31'd0, a_if.step_ready}, 32'd0);
        a_if.branch = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready_bradd", {31'd0, a_if.step_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_pc = RST_PC_A;
        checkOutput("abort_pc", a_if.pc, RST_PC_A);
        checkOutput("abort_pc_valid", {31'd0, a_if.pc_valid}, 32'd0);
        checkOutput("abort_ready_idle", {31'd0, a_if.step_ready}, 32'd1);
        exp_q.push_back(RST_PC_A + 32'd4);
        @(negedge clk);
        a_if.step_valid = 1'b0;
        checkOutput("held_step_busy", {31'd0, a_if.step_ready}, 32'd0);
        @(negedge clk);
        checkOutput("held_step_commit", {31'd0, a_if.pc_valid}, 32'd1);
        model_pc = RST_PC_A + 32'd4;

        applyStimulus(1'b0, 16'h0000, 1'b0, 26'h0);
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0040_0000, byte address loaded into pc on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 step_valid  input  1  request to advance PC by one instruction.
REQ-005 step_ready  output  1  high only in IDLE; a step is accepted on the edge where step_valid && step_ready.
REQ-006 branch  input  1  take a PC-relative branch on this step; sampled at acceptance.
REQ-007 imm16  input  16  signed word offset for branch; sampled at acceptance.
REQ-008 jump  input  1  take an absolute jump on this step; sampled at acceptance.
REQ-009 jtarget  input  26  jump word index; sampled at acceptance.
REQ-010 pc  output  32  current byte-address PC; registered; bits [1:0] always 0.
REQ-011 pc_valid  output  1  one-cycle pulse in the cycle after a new pc is committed.

Function
REQ-012 The block SHALL own exactly one 30-bit adder on pc[31:2] and time-share it between increment and branch-target adds.
REQ-013 States: IDLE, INCR, BRADD; encoding 2 bits.
REQ-014 IDLE: step_ready=1; on acceptance, latch branch, jump, imm16, jtarget and go to INCR; otherwise stay.
REQ-015 INCR: adder A=pc[31:2], B=30'd1, sum -> npc register (30 bits).
REQ-016 INCR, jump=1 (latched): pc <= {sum[29:26], jtarget, 2'b00}; go to IDLE.
REQ-017 INCR, branch=1, jump=0: go to BRADD; pc unchanged.
REQ-018 INCR, neither: pc <= {sum, 2'b00}; go to IDLE.
REQ-019 BRADD: adder A=npc, B=sign-extended imm16 to 30 bits; pc <= {sum, 2'b00}; go to IDLE.
REQ-020 Latency from acceptance edge to commit edge: 1 cycle for sequential or jump, 2 cycles for branch; pc_valid high the cycle after commit, so back-to-back steps give one commit per 2 cycles (sequential).
REQ-021 Adder carry-out SHALL be discarded: arithmetic is mod 2^30 words (0xFFFF_FFFC + 4 = 0x0000_0000; negative offsets wrap).
REQ-022 branch and jump both high: jump wins; BRADD not entered.
REQ-023 step_valid while not IDLE: ignored, not queued; inputs not re-sampled.
REQ-024 pc SHALL change only on commit edges or reset.

Reset
REQ-025 rst high at an edge: state=IDLE, pc=RESET_PC, npc=0, latched controls=0, pc_valid=0 next cycle; takes priority over any acceptance or commit in the same cycle.
REQ-026 Reset mid-operation (INCR or BRADD) SHALL abort the step with no commit and no pc_valid pulse.

Configuration
REQ-027 Macro PC_SEQ_JUMP_EN: defined -> REQ-008/009/016/022 behaviour as specified.
REQ-028 PC_SEQ_JUMP_EN undefined -> jump and jtarget ports remain but are ignored; steps with jump=1 behave as sequential or branch per branch input.

Structure
REQ-029 Shared package pc_seq_pkg: state encoding constants (IDLE=0, INCR=1, BRADD=2), default RESET_PC, PC word width 30.
REQ-030 One sub-module: pc_adder30, a purely combinational 30-bit add (a, b -> sum, carry-in 0, no carry-out port) instantiated once; operand muxing stays in pc_seq_ctrl.
REQ-031 Target size 120-400 lines of RTL including sub-module.

Verification
REQ-032 rst high 2 cycles, then low -> pc=0x0040_0000, step_ready=1, pc_valid=0.
REQ-033 From reset, step with branch=0, jump=0 -> pc=0x0040_0004 one edge after acceptance, pc_valid pulses once next cycle.
REQ-034 pc=0x0040_0010, step with branch=1, imm16=16'hFFFC -> after 2 edges pc=0x0040_0004; step_ready low during INCR and BRADD.
REQ-035 pc=0x0040_0000, step with branch=1, jump=1, jtarget=26'h000_0100 -> pc=0x0000_0400 after 1 edge (jump wins); without PC_SEQ_JUMP_EN -> branch path taken instead.
REQ-036 RESET_PC=0xFFFF_FFFC, sequential step -> pc=0x0000_0000 (wrap).
REQ-037 Branch accepted, rst asserted during BRADD -> pc=RESET_PC, no pc_valid pulse; step_valid held high throughout is not accepted until IDLE.
